// File: rtl/wb_arbiter.sv
// Register-file write-port arbiter: pipeline writeback has priority, long-latency results are buffered.
// Define WB_ARB_STARVE_EN to build the FIFO starvation counter that drives stall_o.
module wb_arbiter #(
  parameter int unsigned REG_DATA_WIDTH     = 32,
  parameter int unsigned REGFILE_ADDR_WIDTH = 5,
  parameter int unsigned REGFILE_DEPTH      = 32,
  parameter int unsigned FIFO_DEPTH         = 4,
  parameter int unsigned STARVE_LIMIT       = 8
) (
  input  logic                          clk_i,
  input  logic                          resetn_i,
  input  logic                          pipe_wr_en_i,
  input  logic [REGFILE_ADDR_WIDTH-1:0] pipe_rd_addr_i,
  input  logic [REG_DATA_WIDTH-1:0]     pipe_wr_data_i,
  input  logic                          mc_valid_i,
  output logic                          mc_ready_o,
  input  logic [REGFILE_ADDR_WIDTH-1:0] mc_rd_addr_i,
  input  logic [REG_DATA_WIDTH-1:0]     mc_data_i,
  output logic                          rd_wr_en_o,
  output logic [REGFILE_ADDR_WIDTH-1:0] rd_addr_o,
  output logic [REG_DATA_WIDTH-1:0]     rd_wr_data_o,
  output logic [REGFILE_DEPTH-1:0]      pending_mask_o,
  output logic                          stall_o
);

  localparam int unsigned    PTR_W      = $clog2(FIFO_DEPTH);
  localparam logic [PTR_W:0] FULL_COUNT = (PTR_W+1)'(FIFO_DEPTH);

  logic [REGFILE_ADDR_WIDTH-1:0] addr_q [FIFO_DEPTH];
  logic [REG_DATA_WIDTH-1:0]     data_q [FIFO_DEPTH];
  logic [PTR_W-1:0]              rd_ptr_q, wr_ptr_q;
  logic [PTR_W:0]                count_q;

  logic pipe_valid, mc_keep, fifo_empty, do_pop, do_direct, do_push;

  assign pipe_valid = pipe_wr_en_i && (pipe_rd_addr_i != '0);
  // Ready is based on the pre-pop count, so a full FIFO refuses even while it pops.
  assign mc_ready_o = resetn_i && (count_q != FULL_COUNT);
  assign mc_keep    = mc_valid_i && mc_ready_o && (mc_rd_addr_i != '0);
  assign fifo_empty = (count_q == '0);
  assign do_pop     = !pipe_valid && !fifo_empty;
  assign do_direct  = !pipe_valid && fifo_empty && mc_keep;
  assign do_push    = mc_keep && !do_direct;

  always_ff @(posedge clk_i) begin
    if (do_push) begin
      addr_q[wr_ptr_q] <= mc_rd_addr_i;
      data_q[wr_ptr_q] <= mc_data_i;
    end
  end

  always_ff @(posedge clk_i or negedge resetn_i) begin
    if (!resetn_i) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + (PTR_W+1)'(1);
        2'b01:   count_q <= count_q - (PTR_W+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge resetn_i) begin
    if (!resetn_i) begin
      rd_wr_en_o   <= 1'b0;
      rd_addr_o    <= '0;
      rd_wr_data_o <= '0;
    end else begin
      rd_wr_en_o <= pipe_valid || do_pop || do_direct;
      if (pipe_valid) begin
        rd_addr_o    <= pipe_rd_addr_i;
        rd_wr_data_o <= pipe_wr_data_i;
      end else if (do_pop) begin
        rd_addr_o    <= addr_q[rd_ptr_q];
        rd_wr_data_o <= data_q[rd_ptr_q];
      end else if (do_direct) begin
        rd_addr_o    <= mc_rd_addr_i;
        rd_wr_data_o <= mc_data_i;
      end
    end
  end

  logic [PTR_W-1:0] slot;

  // Only slots within count_q of the read pointer hold live entries.
  always_comb begin
    pending_mask_o = '0;
    slot           = '0;
    for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
      slot = rd_ptr_q + PTR_W'(i);
      if ((PTR_W+1)'(i) < count_q) pending_mask_o[addr_q[slot]] = 1'b1;
    end
    pending_mask_o[0] = 1'b0;
  end

`ifdef WB_ARB_STARVE_EN
  localparam int unsigned  STARVE_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [STARVE_W-1:0] LIMIT = STARVE_W'(STARVE_LIMIT);

  logic [STARVE_W-1:0] starve_q;

  // stall_o rises on the same edge the counter reaches LIMIT and drops on the pop edge.
  always_ff @(posedge clk_i or negedge resetn_i) begin
    if (!resetn_i) begin
      starve_q <= '0;
      stall_o  <= 1'b0;
    end else if (do_pop || fifo_empty) begin
      starve_q <= '0;
      stall_o  <= 1'b0;
    end else begin
      if (starve_q != LIMIT) starve_q <= starve_q + STARVE_W'(1);
      stall_o <= (starve_q >= LIMIT - STARVE_W'(1));
    end
  end
`else
  logic unused_starve_limit;
  assign unused_starve_limit = |STARVE_LIMIT;
  assign stall_o             = 1'b0;
`endif

endmodule

// File: tb/tb_wb_arbiter.sv
// Randomized and directed bench for wb_arbiter against a queue-based reference model.
module tb_wb_arbiter;

  localparam int unsigned DW      = 32;
  localparam int unsigned AW      = 5;
  localparam int unsigned DEPTH   = 32;
  localparam int unsigned FDEPTH  = 4;
  localparam int unsigned SLIMIT  = 8;

  logic            clk;
  logic            resetn;
  logic            pipe_wr_en;
  logic [AW-1:0]   pipe_rd_addr;
  logic [DW-1:0]   pipe_wr_data;
  logic            mc_valid;
  logic            mc_ready;
  logic [AW-1:0]   mc_rd_addr;
  logic [DW-1:0]   mc_data;
  logic            rd_wr_en;
  logic [AW-1:0]   rd_addr;
  logic [DW-1:0]   rd_wr_data;
  logic [DEPTH-1:0] pending_mask;
  logic            stall;

  wb_arbiter #(
    .REG_DATA_WIDTH    (DW),
    .REGFILE_ADDR_WIDTH(AW),
    .REGFILE_DEPTH     (DEPTH),
    .FIFO_DEPTH        (FDEPTH),
    .STARVE_LIMIT      (SLIMIT)
  ) dut (
    .clk_i         (clk),
    .resetn_i      (resetn),
    .pipe_wr_en_i  (pipe_wr_en),
    .pipe_rd_addr_i(pipe_rd_addr),
    .pipe_wr_data_i(pipe_wr_data),
    .mc_valid_i    (mc_valid),
    .mc_ready_o    (mc_ready),
    .mc_rd_addr_i  (mc_rd_addr),
    .mc_data_i     (mc_data),
    .rd_wr_en_o    (rd_wr_en),
    .rd_addr_o     (rd_addr),
    .rd_wr_data_o  (rd_wr_data),
    .pending_mask_o(pending_mask),
    .stall_o       (stall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: the FIFO is a plain queue; outputs are what the next edge must show.
  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } ent_t;

  ent_t          fq[$];
  logic          exp_en;
  logic [AW-1:0] exp_addr;
  logic [DW-1:0] exp_data;
  logic          exp_stall;
  int unsigned   wait_cnt;

  task automatic model_reset();
    fq.delete();
    exp_en    = 1'b0;
    exp_addr  = '0;
    exp_data  = '0;
    exp_stall = 1'b0;
    wait_cnt  = 0;
  endtask

  task automatic step(input logic pe, input logic [AW-1:0] pa, input logic [DW-1:0] pd,
                      input logic mv, input logic [AW-1:0] ma, input logic [DW-1:0] md);
    logic             pv, keep, popped, was_nonempty, exp_ready;
    logic [DEPTH-1:0] exp_mask;
    ent_t             e;
    pipe_wr_en   = pe;
    pipe_rd_addr = pa;
    pipe_wr_data = pd;
    mc_valid     = mv;
    mc_rd_addr   = ma;
    mc_data      = md;
    #2;
    exp_ready = (fq.size() != FDEPTH);
    exp_mask  = '0;
    foreach (fq[i]) exp_mask[fq[i].addr] = 1'b1;
    check("mc_ready", 64'(mc_ready), 64'(exp_ready));
    check("pending_mask", 64'(pending_mask), 64'(exp_mask));

    was_nonempty = (fq.size() != 0);
    pv     = pe && (pa != 0);
    keep   = mv && exp_ready && (ma != 0);
    popped = 1'b0;
    if (pv) begin
      exp_en = 1'b1; exp_addr = pa; exp_data = pd;
    end else if (was_nonempty) begin
      e = fq.pop_front();
      exp_en = 1'b1; exp_addr = e.addr; exp_data = e.data;
      popped = 1'b1;
    end else if (keep) begin
      exp_en = 1'b1; exp_addr = ma; exp_data = md;
      keep = 1'b0;
    end else begin
      exp_en = 1'b0;
    end
    if (keep) fq.push_back(ent_t'{addr: ma, data: md});
`ifdef WB_ARB_STARVE_EN
    if (popped || !was_nonempty) begin
      wait_cnt  = 0;
      exp_stall = 1'b0;
    end else begin
      if (wait_cnt < SLIMIT) wait_cnt++;
      exp_stall = (wait_cnt >= SLIMIT);
    end
`else
    exp_stall = 1'b0;
`endif

    @(posedge clk);
    #1;
    check("rd_wr_en", 64'(rd_wr_en), 64'(exp_en));
    if (exp_en) begin
      check("rd_addr", 64'(rd_addr), 64'(exp_addr));
      check("rd_wr_data", 64'(rd_wr_data), 64'(exp_data));
    end
    check("stall", 64'(stall), 64'(exp_stall));
  endtask

  task automatic idle();
    step(1'b0, '0, '0, 1'b0, '0, '0);
  endtask

  initial begin
    resetn       = 1'b0;
    pipe_wr_en   = 1'b0;
    pipe_rd_addr = '0;
    pipe_wr_data = '0;
    mc_valid     = 1'b0;
    mc_rd_addr   = '0;
    mc_data      = '0;
    model_reset();
    @(posedge clk);
    @(posedge clk);
    #1;
    check("rst_wr_en", 64'(rd_wr_en), 64'd0);
    check("rst_addr", 64'(rd_addr), 64'd0);
    check("rst_data", 64'(rd_wr_data), 64'd0);
    check("rst_stall", 64'(stall), 64'd0);
    check("rst_mask", 64'(pending_mask), 64'd0);
    check("rst_ready", 64'(mc_ready), 64'd0);
    resetn = 1'b1;
    #1;
    check("rel_ready", 64'(mc_ready), 64'd1);

    // x0 filtering
    step(1'b1, 5'd5, 32'h1234, 1'b0, '0, '0);
    check("x0_addr", 64'(rd_addr), 64'd5);
    check("x0_data", 64'(rd_wr_data), 64'h1234);
    step(1'b1, 5'd0, 32'hFFFF, 1'b0, '0, '0);
    check("x0_no_write", 64'(rd_wr_en), 64'd0);

    // Direct path, then a discarded long-latency write to x0
    step(1'b0, '0, '0, 1'b1, 5'd7, 32'hA5A5);
    check("direct_addr", 64'(rd_addr), 64'd7);
    step(1'b0, '0, '0, 1'b1, 5'd0, 32'hBEEF);
    check("mc_x0_dropped", 64'(rd_wr_en), 64'd0);

    // Buffering behind continuous pipeline writes, then drain with a fifth result offered
    for (int unsigned i = 1; i <= 4; i++)
      step(1'b1, 5'(20 + i), $urandom, 1'b1, 5'(i), 32'(i * 16'h1111));
    #1;
    check("full_ready", 64'(mc_ready), 64'd0);
    check("full_mask", 64'(pending_mask), 64'h1E);
    step(1'b1, 5'd30, $urandom, 1'b1, 5'd5, 32'h5555);
    step(1'b0, '0, '0, 1'b1, 5'd5, 32'h5555);
    check("drain_first", 64'(rd_addr), 64'd1);
    step(1'b0, '0, '0, 1'b1, 5'd5, 32'h5555);
    for (int unsigned i = 0; i < 4; i++) idle();

    // Starvation: one buffered entry behind back-to-back pipeline writes
    step(1'b1, 5'd12, $urandom, 1'b1, 5'd9, 32'h9999);
    for (int unsigned i = 0; i < 7; i++) step(1'b1, 5'd12, $urandom, 1'b0, '0, '0);
    check("starve_before", 64'(stall), 64'd0);
    step(1'b1, 5'd13, $urandom, 1'b0, '0, '0);
`ifdef WB_ARB_STARVE_EN
    check("starve_set", 64'(stall), 64'd1);
`else
    check("starve_off", 64'(stall), 64'd0);
`endif
    step(1'b1, 5'd13, $urandom, 1'b0, '0, '0);
    idle();
    check("starve_pop_addr", 64'(rd_addr), 64'd9);
    check("starve_clear", 64'(stall), 64'd0);
    idle();

    // Reset mid-operation with three entries buffered
    for (int unsigned i = 0; i < 3; i++)
      step(1'b1, 5'd3, $urandom, 1'b1, 5'(10 + i), $urandom);
    check("pre_reset_mask", 64'(pending_mask), 64'h1C00);
    resetn = 1'b0;
    #1;
    check("async_mask", 64'(pending_mask), 64'd0);
    check("async_wr_en", 64'(rd_wr_en), 64'd0);
    check("async_ready", 64'(mc_ready), 64'd0);
    model_reset();
    @(posedge clk);
    @(posedge clk);
    #1;
    resetn = 1'b1;
    #1;
    check("rerel_ready", 64'(mc_ready), 64'd1);

    // Randomized traffic, alternating busy and light pipeline phases
    for (int unsigned n = 0; n < 600; n++) begin
      logic          pe, mv;
      logic [AW-1:0] pa, ma;
      int unsigned   busy;
      busy = ((n / 50) % 2 == 0) ? 90 : 35;
      pe = ($urandom_range(0, 99) < busy);
      mv = ($urandom_range(0, 99) < 45);
      pa = AW'($urandom_range(0, 31));
      ma = AW'($urandom_range(0, 31));
      if ($urandom_range(0, 7) == 0) pa = '0;
      if ($urandom_range(0, 7) == 0) ma = '0;
      step(pe, pa, $urandom, mv, ma, $urandom);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
